mips8_ctrl_alu: RTL and testbench

//   Decode and execute core of the 8-bit single-cycle MIPS-like CPU. Bundles three

---
 rtl/mips8_ctrl_alu.sv | 182 ++++++++++++++++++
 tb/tb_mips8_ctrl_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips8_ctrl_alu.sv
// Decode/execute core of an 8-bit single-cycle MIPS-like CPU: control decode, ALU-control decode, ALU, flag register.
// Latency: strobes, alu_ctrl, alu_result, zero, cout, branch_taken are combinational; zero_q/cout_q lag by one clk.
// Backpressure: none; the block accepts a new instruction every cycle and the flag registers update every edge.
//
// Ports:
//   clk, reset            rising-edge clock; synchronous active-low reset (0 = reset)
//   opcode, funct         instr[14:12] and instr[2:0]; funct only matters for R-type
//   a, b                  ALU operands (b already muxed between register and immediate)
//   reg_dst .. jump       datapath strobes, all forced to 0 while reset is low
//   alu_ctrl              decoded ALU function
//   alu_result/zero/cout  combinational ALU outputs
//   branch_taken          branch & zero
//   zero_q, cout_q        flags registered from zero/cout
module mips8_ctrl_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             cout,
    output logic             branch_taken,
    output logic             zero_q,
    output logic             cout_q
);

    // Opcodes
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;

    // ALU functions
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    ctrl_t ctrl_dec;
    ctrl_t ctrl_gated;

    // ------------------------------------------------------------------
    // Main control + ALU-control decode
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_dec = '0;
        alu_ctrl = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl_dec.reg_dst   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                alu_ctrl           = funct;
            end
            OP_LW: begin
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.mem_read   = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_dec.branch = 1'b1;
                alu_ctrl        = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                alu_ctrl           = ALU_SLT;
            end
            OP_J: begin
                ctrl_dec.jump = 1'b1;
            end
            default: begin
                // reserved opcode: NOP, ADD on the ALU
            end
        endcase
    end

    // Only the strobes are gated by reset; alu_ctrl and the ALU keep decoding
    // so the datapath is already settled the cycle reset is released.
    assign ctrl_gated = reset ? ctrl_dec : '0;

    assign reg_dst    = ctrl_gated.reg_dst;
    assign alu_src    = ctrl_gated.alu_src;
    assign mem_to_reg = ctrl_gated.mem_to_reg;
    assign reg_write  = ctrl_gated.reg_write;
    assign mem_read   = ctrl_gated.mem_read;
    assign mem_write  = ctrl_gated.mem_write;
    assign branch     = ctrl_gated.branch;
    assign jump       = ctrl_gated.jump;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           slt;

    // One extra bit captures the carry; for subtraction that bit is the
    // borrow, so no-borrow (a >= b unsigned) is its inverse.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign slt      = $signed(a) < $signed(b);

    always_comb begin
        alu_result = '0;
        cout       = 1'b0;
        unique case (alu_ctrl)
            ALU_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                cout       = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                alu_result = diff_ext[WIDTH-1:0];
                cout       = ~diff_ext[WIDTH];
            end
            ALU_AND: alu_result = a & b;
            ALU_OR:  alu_result = a | b;
            ALU_XOR: alu_result = a ^ b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLL: alu_result = a << b[2:0];
            ALU_SRL: alu_result = a >> b[2:0];
            default: alu_result = '0;
        endcase
    end

    assign zero         = (alu_result == '0);
    assign branch_taken = branch & zero;

    // ------------------------------------------------------------------
    // Flag register
    // ------------------------------------------------------------------
    logic zero_d;
    logic cout_d;

    assign zero_d = reset ? zero : 1'b0;
    assign cout_d = reset ? cout : 1'b0;

    always_ff @(posedge clk) begin
        zero_q <= zero_d;
        cout_q <= cout_d;
    end

endmodule

// File: tb/tb_mips8_ctrl_alu.sv
// Directed testbench for mips8_ctrl_alu: vector table plus reset sequences.
// Latency: combinational outputs checked #1 after input change; flags checked #1 after the next rising edge.
// Backpressure: none.
module tb_mips8_ctrl_alu;

    logic       clk;
    logic       reset;
    logic [2:0] opcode;
    logic [2:0] funct;
    logic [7:0] a;
    logic [7:0] b;
    logic       reg_dst, alu_src, mem_to_reg, reg_write;
    logic       mem_read, mem_write, branch, jump;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_result;
    logic       zero, cout, branch_taken, zero_q, cout_q;

    int n_cmp;
    int n_bad;

    mips8_ctrl_alu #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .a            (a),
        .b            (b),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch       (branch),
        .jump         (jump),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .zero         (zero),
        .cout         (cout),
        .branch_taken (branch_taken),
        .zero_q       (zero_q),
        .cout_q       (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump
    logic [7:0] strobes;
    assign strobes = {reg_dst, alu_src, mem_to_reg, reg_write,
                      mem_read, mem_write, branch, jump};

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [2:0] fn;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] e_strb;
        logic [2:0] e_ctrl;
        logic [7:0] e_res;
        logic       e_zero;
        logic       e_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [2:0] op, input logic [2:0] fn,
                           input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] st, input logic [2:0] ct,
                           input logic [7:0] rs, input logic z, input logic c);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.va = va; v.vb = vb;
        v.e_strb = st; v.e_ctrl = ct; v.e_res = rs; v.e_zero = z; v.e_cout = c;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //        name          op     fn     a      b      strobes ctrl   result z  c
        add_vec("r_add_7f",   3'd0, 3'd0, 8'h7F, 8'h01, 8'h90, 3'd0, 8'h80, 0, 0);
        add_vec("beq_eq",     3'd3, 3'd7, 8'h3C, 8'h3C, 8'h02, 3'd1, 8'h00, 1, 1);
        add_vec("lw",         3'd1, 3'd6, 8'h10, 8'h05, 8'h78, 3'd0, 8'h15, 0, 0);
        add_vec("sw",         3'd2, 3'd5, 8'h10, 8'h05, 8'h44, 3'd0, 8'h15, 0, 0);
        add_vec("slt_neg",    3'd0, 3'd5, 8'hFE, 8'h01, 8'h90, 3'd5, 8'h01, 0, 0);
        add_vec("slt_swap",   3'd0, 3'd5, 8'h01, 8'hFE, 8'h90, 3'd5, 8'h00, 1, 0);
        add_vec("sll_3",      3'd0, 3'd6, 8'h81, 8'h03, 8'h90, 3'd6, 8'h08, 0, 0);
        add_vec("add_wrap",   3'd0, 3'd0, 8'hFF, 8'h01, 8'h90, 3'd0, 8'h00, 1, 1);
        add_vec("sub_borrow", 3'd0, 3'd1, 8'h05, 8'h07, 8'h90, 3'd1, 8'hFE, 0, 0);
        add_vec("sub_nobor",  3'd0, 3'd1, 8'h07, 8'h05, 8'h90, 3'd1, 8'h02, 0, 1);
        add_vec("and",        3'd0, 3'd2, 8'hF0, 8'h3C, 8'h90, 3'd2, 8'h30, 0, 0);
        add_vec("or",         3'd0, 3'd3, 8'hF0, 8'h0F, 8'h90, 3'd3, 8'hFF, 0, 0);
        add_vec("xor_zero",   3'd0, 3'd4, 8'hFF, 8'hFF, 8'h90, 3'd4, 8'h00, 1, 0);
        add_vec("srl_7",      3'd0, 3'd7, 8'h80, 8'h07, 8'h90, 3'd7, 8'h01, 0, 0);
        add_vec("sll_0",      3'd0, 3'd6, 8'hA5, 8'h08, 8'h90, 3'd6, 8'hA5, 0, 0);
        add_vec("srl_0",      3'd0, 3'd7, 8'hA5, 8'h00, 8'h90, 3'd7, 8'hA5, 0, 0);
        add_vec("sll_7",      3'd0, 3'd6, 8'h81, 8'h07, 8'h90, 3'd6, 8'h80, 0, 0);
        add_vec("addi",       3'd4, 3'd1, 8'h7F, 8'h7F, 8'h50, 3'd0, 8'hFE, 0, 0);
        add_vec("slti",       3'd5, 3'd0, 8'h80, 8'h7F, 8'h50, 3'd5, 8'h01, 0, 0);
        add_vec("jump",       3'd6, 3'd1, 8'h00, 8'h00, 8'h01, 3'd0, 8'h00, 1, 0);
        add_vec("reserved",   3'd7, 3'd3, 8'h12, 8'h34, 8'h00, 3'd0, 8'h46, 0, 0);
        add_vec("beq_ne",     3'd3, 3'd0, 8'h3C, 8'h3D, 8'h02, 3'd1, 8'hFF, 0, 0);
        add_vec("add_80_80",  3'd0, 3'd0, 8'h80, 8'h80, 8'h90, 3'd0, 8'h00, 1, 1);

        // ---- reset held low with an LW in flight ----
        reset = 1'b0; opcode = 3'd1; funct = 3'd0; a = 8'h10; b = 8'h05;
        #1;
        check("rst_strobes", strobes, 8'h00);
        check("rst_alu_ctrl", {5'd0, alu_ctrl}, 8'h00);
        check("rst_alu_result", alu_result, 8'h15);
        @(posedge clk); #1;
        check("rst_zero_q", {7'd0, zero_q}, 8'h00);
        check("rst_cout_q", {7'd0, cout_q}, 8'h00);

        // BEQ a==b under reset: ALU flags set, strobes and registered flags held at 0
        opcode = 3'd3; a = 8'h3C; b = 8'h3C;
        #1;
        check("rst_beq_strobes", strobes, 8'h00);
        check("rst_beq_taken", {7'd0, branch_taken}, 8'h00);
        check("rst_beq_zero", {7'd0, zero}, 8'h01);
        @(posedge clk); #1;
        check("rst_beq_zero_q", {7'd0, zero_q}, 8'h00);
        check("rst_beq_cout_q", {7'd0, cout_q}, 8'h00);

        // release mid-cycle: strobes follow opcode without waiting for an edge
        reset = 1'b1;
        #1;
        check("rel_strobes", strobes, 8'h02);
        check("rel_taken", {7'd0, branch_taken}, 8'h01);
        @(posedge clk); #1;
        check("rel_zero_q", {7'd0, zero_q}, 8'h01);
        check("rel_cout_q", {7'd0, cout_q}, 8'h01);

        // ---- vector table ----
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; a = vecs[i].va; b = vecs[i].vb;
            #1;
            check({vecs[i].name, "_strobes"}, strobes, vecs[i].e_strb);
            check({vecs[i].name, "_alu_ctrl"}, {5'd0, alu_ctrl}, {5'd0, vecs[i].e_ctrl});
            check({vecs[i].name, "_result"}, alu_result, vecs[i].e_res);
            check({vecs[i].name, "_zero"}, {7'd0, zero}, {7'd0, vecs[i].e_zero});
            check({vecs[i].name, "_cout"}, {7'd0, cout}, {7'd0, vecs[i].e_cout});
            check({vecs[i].name, "_taken"}, {7'd0, branch_taken},
                  {7'd0, vecs[i].e_strb[1] & vecs[i].e_zero});
            @(posedge clk); #1;
            check({vecs[i].name, "_zero_q"}, {7'd0, zero_q}, {7'd0, vecs[i].e_zero});
            check({vecs[i].name, "_cout_q"}, {7'd0, cout_q}, {7'd0, vecs[i].e_cout});
        end

        // ---- reassert reset while flags are set (last vector left both at 1) ----
        reset = 1'b0;
        #1;
        check("rst2_strobes", strobes, 8'h00);
        check("rst2_zero_q_before_edge", {7'd0, zero_q}, 8'h01);
        @(posedge clk); #1;
        check("rst2_zero_q", {7'd0, zero_q}, 8'h00);
        check("rst2_cout_q", {7'd0, cout_q}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
